store_buffer: RTL and testbench
===============================

STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, giving the number of buffered committed stores (power of two, at least 2).
REQ-002 SHALL have port clk, input, 1 bit: the single clock.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port in_valid, input, 1 bit: a committed store is presented this cycle.
REQ-005 SHALL have port in_addr, input, pptr_t: the physical store address (tag/idx/offset fields, 4-bit offset).
REQ-006 SHALL have port in_data, input, word_t (32 bits): the store data.
REQ-007 SHALL have port in_isbyte, input, 1 bit: the store is a byte store (in_data[7:0] only).
REQ-008 SHALL have port full, output, 1 bit: no free entry; upstream holds its store.
REQ-009 SHALL have port empty, output, 1 bit: no valid entry.
REQ-010 SHALL have port count, output, $clog2(DEPTH)+1 bits: the number of valid entries.
REQ-011 SHALL have port drain_block, input, 1 bit: the dcache store port cannot accept a store this cycle.
REQ-012 SHALL have ports store_en (1), store_isbyte (1), store_addr (pptr_t), store_data (word_t), all outputs: the dcache store port.
REQ-013 SHALL have ports ld_valid (input, 1), ld_addr (input, pptr_t), ld_isbyte (input, 1): the load lookup.
REQ-014 SHALL have ports fwd_hit (output, 1), fwd_data (output, word_t), fwd_conflict (output, 1): the forwarding result.

Function
REQ-015 SHALL be a circular FIFO: head/tail pointers of $clog2(DEPTH) bits wrapping DEPTH-1 to 0, plus a per-entry valid bit.
REQ-016 SHALL enqueue at the tail on a clock edge where in_valid=1 and full=0; when full=1, in_valid SHALL be ignored and no state changes.
REQ-017 SHALL compute full (count==DEPTH) and empty (count==0) from registered state only; a same-cycle drain SHALL NOT unblock enqueue when full.
REQ-018 SHALL store zero in bits [31:8] of the entry data for a byte store.
REQ-019 SHALL drive store_en = !empty && !drain_block combinationally, with store_addr/store_data/store_isbyte taken from the head entry; the head pops at the edge where store_en=1.
REQ-020 SHALL NOT bypass: a store enqueued at edge N can first drive store_en in the cycle after edge N.
REQ-021 SHALL, on simultaneous enqueue and pop, leave count unchanged and advance both pointers.
REQ-022 SHALL drive store_addr/store_data/store_isbyte to 0 when store_en=0.
REQ-023 SHALL perform forwarding combinationally; an entry overlaps a load when the {tag, idx, offset[3:2]} word addresses are equal and either access is a word access, or both are byte accesses with equal offset[1:0].
REQ-024 SHALL let the youngest overlapping valid entry decide the result; entries not yet enqueued are excluded; the head entry popping this cycle is included.
REQ-025 SHALL, when the youngest overlap is a word entry, set fwd_hit=1 with fwd_data = the full word for a word load, or {24'b0, byte k} for a byte load with k = ld_addr offset[1:0].
REQ-026 SHALL, when the youngest overlap is a byte entry and the load is a byte load, set fwd_hit=1 with fwd_data = {24'b0, entry byte}.
REQ-027 SHALL, when the youngest overlap is a byte entry and the load is a word load, set fwd_conflict=1, fwd_hit=0, fwd_data=0.
REQ-028 SHALL drive fwd_hit=0, fwd_conflict=0 and fwd_data=0 when ld_valid=0 or no entry overlaps.
REQ-029 SHALL place byte k of a word at bits [8k+7:8k].

Reset
REQ-030 SHALL, on an edge with rst=1, clear all valid bits, pointers and count, regardless of in_valid or store_en; buffered stores are discarded.
REQ-031 SHALL, after reset: empty=1, full=0, count=0, store_en=0, fwd_hit=0, fwd_conflict=0, all data outputs 0.

Verification
REQ-032 SHALL cover fill/drain: enqueue 4 word stores (A0..A3) with drain_block=1 -> full=1, count=4; a 5th in_valid is ignored; release drain_block -> store_en on A0..A3 in order on 4 consecutive cycles, then empty=1.
REQ-033 SHALL cover wrap-around: 6 interleaved enqueues/pops, each with drain_block=0 -> FIFO order preserved across the pointer wrap; count never exceeds 4.
REQ-034 SHALL cover forwarding priority: word store 0x11223344 to address 0x100, then byte store 0xAA to 0x101; byte load 0x101 -> fwd_hit=1, fwd_data=0xAA; byte load 0x102 -> fwd_data=0x22; word load 0x100 -> fwd_conflict=1.
REQ-035 SHALL cover simultaneous events: count=4 with in_valid=1 and a pop in the same cycle -> the new store is not accepted, count=3 after the edge.
REQ-036 SHALL cover reset mid-operation: count=3 and rst=1 for one cycle -> empty=1, store_en=0 next cycle, and a prior forwarding hit now yields fwd_hit=0.
REQ-037 SHALL cover the no-bypass rule: in_valid into the empty buffer -> store_en=0 in the same cycle and 1 in the following cycle.

Source files
------------

// File: rtl/store_buffer.sv
// store_buffer: committed-store FIFO sitting between retirement and the dcache
// store port, with combinational store-to-load forwarding.
//
// Ports
//   clk, rst                     single clock, synchronous active-high reset
//   in_valid/in_addr/in_data/in_isbyte   committed store presented for enqueue
//   full, empty, count           occupancy status (from registered state)
//   drain_block                  dcache store port cannot accept this cycle
//   store_en/store_isbyte/store_addr/store_data   dcache store port (head entry)
//   ld_valid/ld_addr/ld_isbyte   load lookup
//   fwd_hit/fwd_data/fwd_conflict   forwarding result

package store_buffer_pkg;
    localparam int unsigned TAG_W  = 20;
    localparam int unsigned IDX_W  = 8;
    localparam int unsigned OFF_W  = 4;
    localparam int unsigned WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [IDX_W-1:0] idx;
        logic [OFF_W-1:0] offset;
    } pptr_t;
endpackage

module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  pptr_t                    in_addr,
    input  word_t                    in_data,
    input  logic                     in_isbyte,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    input  logic                     drain_block,
    output logic                     store_en,
    output logic                     store_isbyte,
    output pptr_t                    store_addr,
    output word_t                    store_data,
    input  logic                     ld_valid,
    input  pptr_t                    ld_addr,
    input  logic                     ld_isbyte,
    output logic                     fwd_hit,
    output word_t                    fwd_data,
    output logic                     fwd_conflict
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    pptr_t             addr_q   [DEPTH];
    word_t             data_q   [DEPTH];
    logic [DEPTH-1:0]  isbyte_q;
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [PW-1:0]     head_q, head_d;
    logic [PW-1:0]     tail_q, tail_d;
    logic [CW-1:0]     count_q, count_d;
    logic              push;

    // Status, dcache port and next-state control
    always_comb begin
        full         = (count_q == CW'(DEPTH));
        empty        = (count_q == '0);
        count        = count_q;
        store_en     = !empty && !drain_block;
        push         = in_valid && !full;
        store_addr   = '0;
        store_data   = '0;
        store_isbyte = 1'b0;
        valid_d      = valid_q;
        head_d       = head_q;
        tail_d       = tail_q;
        count_d      = count_q;

        if (store_en) begin
            store_addr   = addr_q[head_q];
            store_data   = data_q[head_q];
            store_isbyte = isbyte_q[head_q];
            valid_d[head_q] = 1'b0;
            head_d       = head_q + PW'(1);
        end
        if (push) begin
            valid_d[tail_q] = 1'b1;
            tail_d       = tail_q + PW'(1);
        end
        case ({push, store_en})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state register
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry payload; byte stores keep only the low byte, upper bits zero
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            addr_q[tail_q]   <= in_addr;
            data_q[tail_q]   <= in_isbyte ? {24'b0, in_data[7:0]} : in_data;
            isbyte_q[tail_q] <= in_isbyte;
        end
    end

    // Forwarding: scan oldest to youngest so the last overlap found is the youngest
    logic          fwd_found;
    logic [PW-1:0] fwd_sel;
    logic [PW-1:0] slot;
    logic [1:0]    ld_k;

    always_comb begin
        fwd_found    = 1'b0;
        fwd_sel      = '0;
        slot         = '0;
        ld_k         = ld_addr.offset[1:0];
        fwd_hit      = 1'b0;
        fwd_conflict = 1'b0;
        fwd_data     = '0;

        for (int unsigned i = 0; i < DEPTH; i++) begin
            slot = head_q + PW'(i);
            if (ld_valid && valid_q[slot]
                && ({addr_q[slot].tag, addr_q[slot].idx, addr_q[slot].offset[3:2]}
                    == {ld_addr.tag, ld_addr.idx, ld_addr.offset[3:2]})
                && (!ld_isbyte || !isbyte_q[slot]
                    || (addr_q[slot].offset[1:0] == ld_k))) begin
                fwd_found = 1'b1;
                fwd_sel   = slot;
            end
        end

        if (fwd_found) begin
            if (!isbyte_q[fwd_sel]) begin
                fwd_hit  = 1'b1;
                fwd_data = ld_isbyte ? {24'b0, data_q[fwd_sel][{ld_k, 3'b000} +: 8]}
                                     : data_q[fwd_sel];
            end else if (ld_isbyte) begin
                fwd_hit  = 1'b1;
                fwd_data = {24'b0, data_q[fwd_sel][7:0]};
            end else begin
                // Word load covered only partly by a younger byte store
                fwd_conflict = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;
    import store_buffer_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    pptr_t       in_addr;
    word_t       in_data;
    logic        in_isbyte;
    logic        full, empty;
    logic [2:0]  count;
    logic        drain_block;
    logic        store_en, store_isbyte;
    pptr_t       store_addr;
    word_t       store_data;
    logic        ld_valid;
    pptr_t       ld_addr;
    logic        ld_isbyte;
    logic        fwd_hit, fwd_conflict;
    word_t       fwd_data;

    int total = 0;
    int bad   = 0;

    store_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_addr(in_addr), .in_data(in_data), .in_isbyte(in_isbyte),
        .full(full), .empty(empty), .count(count),
        .drain_block(drain_block),
        .store_en(store_en), .store_isbyte(store_isbyte),
        .store_addr(store_addr), .store_data(store_data),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_isbyte(ld_isbyte),
        .fwd_hit(fwd_hit), .fwd_data(fwd_data), .fwd_conflict(fwd_conflict)
    );

    always #5 clk = ~clk;

    // Reference model: list of committed stores, oldest first
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        isbyte;
    } ent_t;
    ent_t q[$];

    typedef struct {
        logic        in_v;
        logic [31:0] in_a;
        logic [31:0] in_d;
        logic        in_b;
        logic        drain;
        logic        ld_v;
        logic [31:0] ld_a;
        logic        ld_b;
        logic        e_hit;
        logic [31:0] e_data;
        logic        e_conf;
        int          e_count;
    } vec_t;
    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Youngest overlapping store decides; word address = addr / 4
    task automatic model_fwd(output logic hit, output logic conf, output logic [31:0] d);
        logic [31:0] la;
        int k;
        hit = 1'b0; conf = 1'b0; d = 32'h0;
        la = ld_addr;
        k  = int'(la % 4);
        if (!ld_valid) return;
        for (int i = q.size() - 1; i >= 0; i--) begin
            if ((q[i].addr / 4) == (la / 4)
                && (!ld_isbyte || !q[i].isbyte || (q[i].addr % 4) == (la % 4))) begin
                if (!q[i].isbyte) begin
                    hit = 1'b1;
                    d   = ld_isbyte ? ((q[i].data >> (8 * k)) & 32'hFF) : q[i].data;
                end else if (ld_isbyte) begin
                    hit = 1'b1;
                    d   = q[i].data & 32'hFF;
                end else begin
                    conf = 1'b1;
                end
                return;
            end
        end
    endtask

    // Compare every output against the model, then clock one edge and update the model
    task automatic step();
        logic e_en, e_hit, e_conf, push;
        logic [31:0] e_fd, e_sa, e_sd;
        logic e_sb;
        ent_t ne;
        int n;
        n    = q.size();
        e_en = (n != 0) && !drain_block;
        e_sa = 32'h0; e_sd = 32'h0; e_sb = 1'b0;
        if (e_en) begin
            e_sa = q[0].addr;
            e_sb = q[0].isbyte;
            e_sd = q[0].isbyte ? (q[0].data & 32'hFF) : q[0].data;
        end
        model_fwd(e_hit, e_conf, e_fd);
        chk("m_full",     full,         32'(n == DEPTH));
        chk("m_empty",    empty,        32'(n == 0));
        chk("m_count",    count,        32'(n));
        chk("m_store_en", store_en,     32'(e_en));
        chk("m_st_addr",  store_addr,   e_sa);
        chk("m_st_data",  store_data,   e_sd);
        chk("m_st_byte",  store_isbyte, 32'(e_sb));
        chk("m_fwd_hit",  fwd_hit,      32'(e_hit));
        chk("m_fwd_conf", fwd_conflict, 32'(e_conf));
        chk("m_fwd_data", fwd_data,     e_fd);
        push      = in_valid && (n < DEPTH);
        ne.addr   = in_addr;
        ne.data   = in_data;
        ne.isbyte = in_isbyte;
        @(posedge clk);
        if (rst) begin
            q.delete();
        end else begin
            if (e_en) void'(q.pop_front());
            if (push) q.push_back(ne);
        end
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0; in_addr = '0; in_data = '0; in_isbyte = 1'b0;
        ld_valid = 1'b0; ld_addr = '0; ld_isbyte = 1'b0;
    endtask

    task automatic put(input logic [31:0] a, input logic [31:0] d, input logic b);
        in_valid = 1'b1; in_addr = a; in_data = d; in_isbyte = b;
    endtask

    initial begin
        logic [31:0] bases[3];
        bases[0] = 32'h100; bases[1] = 32'h104; bases[2] = 32'h300;

        rst = 1'b1; drain_block = 1'b0;
        idle_inputs();
        put(32'h10, 32'hDEAD, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        q.delete();
        rst = 1'b0;
        idle_inputs();
        #1;
        chk("rst_empty",    empty,        32'd1);
        chk("rst_full",     full,         32'd0);
        chk("rst_count",    count,        32'd0);
        chk("rst_store_en", store_en,     32'd0);
        chk("rst_st_addr",  store_addr,   32'd0);
        chk("rst_st_data",  store_data,   32'd0);
        chk("rst_fwd_hit",  fwd_hit,      32'd0);
        chk("rst_fwd_conf", fwd_conflict, 32'd0);
        step();

        // Forwarding priority table
        vecs[0]  = '{1'b1, 32'h100, 32'h11223344, 1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,  1'b0, 0};
        vecs[1]  = '{1'b1, 32'h101, 32'h000000AA, 1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,  1'b0, 1};
        vecs[2]  = '{1'b0, 32'h0,   32'h0,        1'b0, 1'b1, 1'b1, 32'h101, 1'b1, 1'b1, 32'hAA, 1'b0, 2};
        vecs[3]  = '{1'b0, 32'h0,   32'h0,        1'b0, 1'b1, 1'b1, 32'h102, 1'b1, 1'b1, 32'h22, 1'b0, 2};
        vecs[4]  = '{1'b0, 32'h0,   32'h0,        1'b0, 1'b1, 1'b1, 32'h100, 1'b0, 1'b0, 32'h0,  1'b1, 2};
        vecs[5]  = '{1'b0, 32'h0,   32'h0,        1'b0, 1'b1, 1'b1, 32'h100, 1'b1, 1'b1, 32'h44, 1'b0, 2};
        vecs[6]  = '{1'b0, 32'h0,   32'h0,        1'b0, 1'b1, 1'b1, 32'h103, 1'b1, 1'b1, 32'h11, 1'b0, 2};
        vecs[7]  = '{1'b0, 32'h0,   32'h0,        1'b0, 1'b1, 1'b1, 32'h104, 1'b0, 1'b0, 32'h0,  1'b0, 2};
        vecs[8]  = '{1'b0, 32'h0,   32'h0,        1'b0, 1'b1, 1'b0, 32'h100, 1'b0, 1'b0, 32'h0,  1'b0, 2};
        vecs[9]  = '{1'b0, 32'h0,   32'h0,        1'b0, 1'b0, 1'b1, 32'h101, 1'b1, 1'b1, 32'hAA, 1'b0, 2};
        vecs[10] = '{1'b0, 32'h0,   32'h0,        1'b0, 1'b0, 1'b1, 32'h100, 1'b0, 1'b0, 32'h0,  1'b1, 1};
        vecs[11] = '{1'b0, 32'h0,   32'h0,        1'b0, 1'b1, 1'b1, 32'h100, 1'b0, 1'b0, 32'h0,  1'b0, 0};
        for (int i = 0; i < 12; i++) begin
            in_valid = vecs[i].in_v; in_addr = vecs[i].in_a;
            in_data = vecs[i].in_d;  in_isbyte = vecs[i].in_b;
            drain_block = vecs[i].drain;
            ld_valid = vecs[i].ld_v; ld_addr = vecs[i].ld_a; ld_isbyte = vecs[i].ld_b;
            #1;
            chk($sformatf("vec%0d_hit", i),   fwd_hit,      32'(vecs[i].e_hit));
            chk($sformatf("vec%0d_data", i),  fwd_data,     vecs[i].e_data);
            chk($sformatf("vec%0d_conf", i),  fwd_conflict, 32'(vecs[i].e_conf));
            chk($sformatf("vec%0d_count", i), count,        32'(vecs[i].e_count));
            step();
        end
        idle_inputs();

        // No bypass: a store entering an empty buffer drains one cycle later
        drain_block = 1'b0;
        put(32'h400, 32'h55, 1'b0);
        #1;
        chk("nobyp_same", store_en, 32'd0);
        step();
        idle_inputs();
        #1;
        chk("nobyp_next", store_en, 32'd1);
        chk("nobyp_data", store_data, 32'h55);
        step();

        // Fill then drain in order
        drain_block = 1'b1;
        for (int i = 0; i < 4; i++) begin
            put(32'h200 + 32'(4 * i), 32'hA000_0000 + 32'(i), 1'b0);
            #1;
            step();
        end
        put(32'h220, 32'hFFFF_FFFF, 1'b0);
        #1;
        chk("fill_full",  full,  32'd1);
        chk("fill_count", count, 32'd4);
        step();
        idle_inputs();
        #1;
        chk("fifth_ign", count, 32'd4);
        drain_block = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("drain%0d_en", i),   store_en,   32'd1);
            chk($sformatf("drain%0d_addr", i), store_addr, 32'h200 + 32'(4 * i));
            chk($sformatf("drain%0d_data", i), store_data, 32'hA000_0000 + 32'(i));
            step();
        end
        #1;
        chk("drain_empty", empty, 32'd1);
        chk("drain_en",    store_en, 32'd0);
        step();

        // Full buffer with a pop and a new store in the same cycle
        drain_block = 1'b1;
        for (int i = 0; i < 4; i++) begin
            put(32'h500 + 32'(4 * i), 32'hB0 + 32'(i), 1'b0);
            #1;
            step();
        end
        put(32'h600, 32'hCAFE, 1'b0);
        drain_block = 1'b0;
        #1;
        chk("simul_full", full, 32'd1);
        chk("simul_en",   store_en, 32'd1);
        step();
        idle_inputs();
        drain_block = 1'b1;
        #1;
        chk("simul_cnt", count, 32'd3);

        // Reset mid-operation discards buffered stores
        ld_valid = 1'b1; ld_addr = 32'h508; ld_isbyte = 1'b0;
        #1;
        chk("pre_rst_hit",  fwd_hit,  32'd1);
        chk("pre_rst_data", fwd_data, 32'hB2);
        step();
        rst = 1'b1; drain_block = 1'b0;
        put(32'h700, 32'h1, 1'b0);
        @(posedge clk); #1;
        q.delete();
        rst = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("post_rst_empty", empty,    32'd1);
        chk("post_rst_en",    store_en, 32'd0);
        chk("post_rst_hit",   fwd_hit,  32'd0);
        step();
        idle_inputs();

        // Interleaved enqueue/pop across the pointer wrap
        drain_block = 1'b0;
        for (int i = 0; i < 6; i++) begin
            put(32'h700 + 32'(4 * i), 32'hC0 + 32'(i), 1'b0);
            #1;
            chk($sformatf("wrap%0d_cnt", i), count, (i == 0) ? 32'd0 : 32'd1);
            if (i > 0) chk($sformatf("wrap%0d_data", i), store_data, 32'hC0 + 32'(i - 1));
            step();
        end
        idle_inputs();
        #1;
        chk("wrap_last", store_data, 32'hC5);
        step();

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            rst         = ($urandom_range(63) == 0);
            drain_block = ($urandom_range(2) == 0);
            in_valid    = $urandom_range(1) == 1;
            in_addr     = bases[$urandom_range(2)] | 32'($urandom_range(3));
            in_data     = $urandom;
            in_isbyte   = $urandom_range(1) == 1;
            ld_valid    = $urandom_range(3) != 0;
            ld_addr     = bases[$urandom_range(2)] | 32'($urandom_range(3));
            ld_isbyte   = $urandom_range(1) == 1;
            #1;
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
